// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// sizing constants and the rotating-priority search.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, idx}: the first set request bit when scanning
  // ptr, ptr+1, ptr+2, ptr+3 with 2-bit wraparound.
  function automatic logic [IDX_W:0] next_rr(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    res = '0;
    // Scan from the lowest priority upward so the highest-priority hit wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) res = {1'b1, k};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_grant_decoder.sv
// 2-to-4 one-hot decoder with enable; the only source of one-hot grant bits.
import arb_pkg::*;

module grant_decoder (
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);

  // Decode the owner index, forced to zero when no grant is active.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter for a single-ported shared resource.
// Optional feature macro: ARB_TIMEOUT_EN enables the per-owner hold limit
// (TIMEOUT_CYCLES) with a forced release and a one-cycle timeout pulse.
//
// state | meaning
// IDLE  | no owner; arbitrate any incoming request
// GRANT | one owner holds the resource until done, withdrawal or timeout
import arb_pkg::*;

module rr_arbiter4
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_valid_nxt;
  logic             w_natural;
  logic             w_release;
  logic             w_force;
  logic [IDX_W-1:0] w_arb_ptr;
  logic [IDX_W:0]   w_pick;

  // Owner finished or dropped its request.
  assign w_natural = (r_state == GRANT) && (done || !req[r_idx]);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic [7:0] w_cnt_nxt;
  logic       w_new_grant;

  // A natural release takes precedence, so the forced release never fires with it.
  assign w_force   = (r_state == GRANT) && !w_natural && (r_cnt == TO_LAST);
  assign w_release = w_natural || w_force;

  assign w_new_grant = (w_state_nxt == GRANT) && ((r_state == IDLE) || w_release);
  assign w_cnt_nxt   = (w_new_grant || (w_state_nxt == IDLE)) ? 8'd0 : r_cnt + 8'd1;

  // Hold counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_force;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force   = 1'b0;
  assign w_release = w_natural;
  assign timeout   = 1'b0;
`endif

  // On release the departing owner becomes lowest priority for this same edge.
  assign w_arb_ptr = (r_state == GRANT) ? r_idx + 2'd1 : r_ptr;
  assign w_pick    = next_rr(req, w_arb_ptr);

  // Next-state logic: grant from IDLE, or release and re-arbitrate without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (w_pick[IDX_W]) begin
          w_state_nxt = GRANT;
          w_idx_nxt   = w_pick[IDX_W-1:0];
          w_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_arb_ptr;
          if (w_pick[IDX_W]) begin
            w_idx_nxt = w_pick[IDX_W-1:0];
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;

  grant_decoder u_dec (
    .i_idx    (r_idx),
    .i_en     (r_valid),
    .o_onehot (gnt)
  );

endmodule
